// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: ALU control op/branch encodings, exec FSM states and shift modes
package alu_exec_unit_pkg;
  localparam int kALU_OP_SEL_WIDTH = 4;
  localparam int kALU_BRANCH_SEL_WIDTH = 3;
  localparam logic [3:0] kSAIL_ALUCTL_ADD = 4'd0;
  localparam logic [3:0] kSAIL_ALUCTL_SUB = 4'd1;
  localparam logic [3:0] kSAIL_ALUCTL_SLL = 4'd2;
  localparam logic [3:0] kSAIL_ALUCTL_SLT = 4'd3;
  localparam logic [3:0] kSAIL_ALUCTL_XOR = 4'd4;
  localparam logic [3:0] kSAIL_ALUCTL_SRL = 4'd5;
  localparam logic [3:0] kSAIL_ALUCTL_SRA = 4'd6;
  localparam logic [3:0] kSAIL_ALUCTL_OR = 4'd7;
  localparam logic [3:0] kSAIL_ALUCTL_AND = 4'd8;
  localparam logic [3:0] kSAIL_ALUCTL_ILLEGAL = 4'd15;
  localparam logic [2:0] kSAIL_ALUBR_NONE = 3'd0;
  localparam logic [2:0] kSAIL_ALUBR_BEQ = 3'd1;
  localparam logic [2:0] kSAIL_ALUBR_BNE = 3'd2;
  localparam logic [2:0] kSAIL_ALUBR_BLT = 3'd3;
  localparam logic [2:0] kSAIL_ALUBR_BGE = 3'd4;
  localparam logic [2:0] kSAIL_ALUBR_BLTU = 3'd5;
  localparam logic [2:0] kSAIL_ALUBR_BGEU = 3'd6;
  localparam logic [1:0] kALU_EXEC_IDLE = 2'd0;
  localparam logic [1:0] kALU_EXEC_SHIFT = 2'd1;
  localparam logic [1:0] kALU_EXEC_DONE = 2'd2;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_mode_e;
  function automatic logic op_legal(input logic [kALU_OP_SEL_WIDTH-1:0] op);
    return op <= kSAIL_ALUCTL_AND;
  endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: upstream issue and downstream result handshakes of the execute ALU
interface alu_exec_unit_if import alu_exec_unit_pkg::*; #(parameter int XLEN = 32) ();
  logic in_valid_i;
  logic in_ready_o;
  logic [kALU_OP_SEL_WIDTH-1:0] alu_op_sel_i;
  logic [kALU_BRANCH_SEL_WIDTH-1:0] alu_branch_sel_i;
  logic unsigned_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [XLEN-1:0] result_o;
  logic branch_taken_o;
  logic illegal_o;
  modport master (
    output in_valid_i, alu_op_sel_i, alu_branch_sel_i, unsigned_i, op_a_i, op_b_i, out_ready_i,
    input in_ready_o, out_valid_o, result_o, branch_taken_o, illegal_o
  );
  modport slave (
    input in_valid_i, alu_op_sel_i, alu_branch_sel_i, unsigned_i, op_a_i, op_b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, branch_taken_o, illegal_o
  );
endinterface

// File: rtl/alu_exec_unit_shift_seq.sv
// alu_shift_seq: iterative shifter, one bit per cycle; next_o is the value after the current step
module alu_shift_seq import alu_exec_unit_pkg::*; #(parameter int XLEN = 32) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  shift_mode_e     mode_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [4:0]      shamt_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] next_o
);
  logic [4:0] cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;
  shift_mode_e mode_q, mode_d;
  always_comb begin
    busy_o = cnt_q != 5'd0;
    done_o = cnt_q == 5'd1;
    next_o = mode_q == SH_LL ? data_q << 1 :
             mode_q == SH_RA ? {data_q[XLEN-1], data_q[XLEN-1:1]} : data_q >> 1;
    cnt_d = load_i ? shamt_i : busy_o ? cnt_q - 5'd1 : cnt_q;
    data_d = load_i ? data_i : busy_o ? next_o : data_q;
    mode_d = load_i ? mode_i : mode_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      data_q <= '0;
      mode_q <= SH_LL;
    end else begin
      cnt_q <= cnt_d;
      data_q <= data_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle logic/arith/compare and iterative shifts
module alu_exec_unit import alu_exec_unit_pkg::*; #(parameter int XLEN = 32) (
  input logic clk_i,
  input logic rst_i,
  alu_exec_unit_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, res_new, sh_next, a, b;
  logic taken_q, taken_d, illegal_q, illegal_d, taken_new, illegal_new;
  logic accept, is_shift, sh_load, sh_busy, sh_done, eq, lt_s, lt_u;
  logic [4:0] shamt;
  shift_mode_e sh_mode;
  always_comb begin
    a = bus.op_a_i;
    b = bus.op_b_i;
    bus.in_ready_o = !rst_i && (state_q == kALU_EXEC_IDLE || (state_q == kALU_EXEC_DONE && bus.out_ready_i));
    accept = bus.in_valid_i && bus.in_ready_o;
    shamt = b[4:0];
    eq = a == b;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    is_shift = bus.alu_op_sel_i == kSAIL_ALUCTL_SLL || bus.alu_op_sel_i == kSAIL_ALUCTL_SRL ||
               bus.alu_op_sel_i == kSAIL_ALUCTL_SRA;
    sh_mode = bus.alu_op_sel_i == kSAIL_ALUCTL_SLL ? SH_LL :
              bus.alu_op_sel_i == kSAIL_ALUCTL_SRA ? SH_RA : SH_RL;
    sh_load = accept && is_shift && shamt != 5'd0;
    res_new = '0;
    case (bus.alu_op_sel_i)
      kSAIL_ALUCTL_ADD: res_new = a + b;
      kSAIL_ALUCTL_SUB: res_new = a - b;
      kSAIL_ALUCTL_AND: res_new = a & b;
      kSAIL_ALUCTL_OR:  res_new = a | b;
      kSAIL_ALUCTL_XOR: res_new = a ^ b;
      kSAIL_ALUCTL_SLT: res_new = {{(XLEN-1){1'b0}}, bus.unsigned_i ? lt_u : lt_s};
      kSAIL_ALUCTL_SLL, kSAIL_ALUCTL_SRL, kSAIL_ALUCTL_SRA: res_new = a;
      default: res_new = '0;
    endcase
    taken_new = 1'b0;
    case (bus.alu_branch_sel_i)
      kSAIL_ALUBR_BEQ:  taken_new = eq;
      kSAIL_ALUBR_BNE:  taken_new = !eq;
      kSAIL_ALUBR_BLT:  taken_new = lt_s;
      kSAIL_ALUBR_BGE:  taken_new = !lt_s;
      kSAIL_ALUBR_BLTU: taken_new = lt_u;
      kSAIL_ALUBR_BGEU: taken_new = !lt_u;
      default:          taken_new = 1'b0;
    endcase
    illegal_new = !op_legal(bus.alu_op_sel_i) && bus.alu_branch_sel_i == kSAIL_ALUBR_NONE;
    state_d = accept ? (sh_load ? kALU_EXEC_SHIFT : kALU_EXEC_DONE) :
              state_q == kALU_EXEC_SHIFT ? (sh_busy && !sh_done ? kALU_EXEC_SHIFT : kALU_EXEC_DONE) :
              state_q == kALU_EXEC_DONE ? (bus.out_ready_i ? kALU_EXEC_IDLE : kALU_EXEC_DONE) : state_q;
    result_d = accept ? res_new : (state_q == kALU_EXEC_SHIFT && sh_done) ? sh_next : result_q;
    taken_d = accept ? taken_new : taken_q;
    illegal_d = accept ? illegal_new : illegal_q;
    bus.out_valid_o = state_q == kALU_EXEC_DONE;
    bus.result_o = result_q;
    bus.branch_taken_o = taken_q;
    bus.illegal_o = illegal_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= kALU_EXEC_IDLE;
      result_q <= '0;
      taken_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      taken_q <= taken_d;
      illegal_q <= illegal_d;
    end
  end
  alu_shift_seq #(.XLEN(XLEN)) u_shift (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(sh_load), .mode_i(sh_mode), .data_i(a), .shamt_i(shamt),
    .busy_o(sh_busy), .done_o(sh_done), .next_o(sh_next)
  );
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed table vectors plus shift, back-pressure and reset sequences
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;
  logic clk = 0, rst = 1;
  int n_cmp = 0, n_bad = 0;
  alu_exec_unit_if #(.XLEN(32)) bus ();
  alu_exec_unit #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] op;
    logic [2:0] br;
    logic uns;
    logic [31:0] a, b, res;
    logic tk, il;
  } vec_t;
  vec_t v[17];
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] op, input logic [2:0] br, input logic uns, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid_i = 1;
    bus.alu_op_sel_i = op;
    bus.alu_branch_sel_i = br;
    bus.unsigned_i = uns;
    bus.op_a_i = a;
    bus.op_b_i = b;
  endtask
  task automatic check_vec(input int i);
    chk("vec_valid", i, 32'(bus.out_valid_o), 1);
    chk("vec_result", i, bus.result_o, v[i].res);
    chk("vec_taken", i, 32'(bus.branch_taken_o), 32'(v[i].tk));
    chk("vec_illegal", i, 32'(bus.illegal_o), 32'(v[i].il));
  endtask
  task automatic do_shift(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int k);
    int cyc, ready_seen;
    @(negedge clk);
    bus.out_ready_i = 1;
    drive(op, 3'd0, 0, a, b);
    @(negedge clk);
    bus.out_ready_i = 0;
    drive(kSAIL_ALUCTL_ADD, 3'd0, 0, 32'h1111_1111, 32'h2222_2222);
    cyc = 1;
    ready_seen = 0;
    while (!bus.out_valid_o && cyc < 100) begin
      if (bus.in_ready_o) ready_seen++;
      @(negedge clk);
      cyc++;
    end
    chk("shift_latency", id, cyc, k + 1);
    chk("shift_ready_low", id, ready_seen, 0);
    chk("shift_result", id, bus.result_o, exp);
    chk("shift_illegal", id, 32'(bus.illegal_o), 0);
    bus.in_valid_i = 0;
    bus.out_ready_i = 1;
    @(negedge clk);
    chk("shift_drain", id, 32'(bus.out_valid_o), 0);
  endtask
  initial begin
    int seen;
    v[0]  = '{kSAIL_ALUCTL_ADD, kSAIL_ALUBR_NONE, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    v[1]  = '{kSAIL_ALUCTL_SUB, kSAIL_ALUBR_NONE, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[2]  = '{kSAIL_ALUCTL_AND, kSAIL_ALUBR_NONE, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0};
    v[3]  = '{kSAIL_ALUCTL_OR,  kSAIL_ALUBR_NONE, 1'b0, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0};
    v[4]  = '{kSAIL_ALUCTL_XOR, kSAIL_ALUBR_NONE, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0};
    v[5]  = '{kSAIL_ALUCTL_SLT, kSAIL_ALUBR_NONE, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    v[6]  = '{kSAIL_ALUCTL_SLT, kSAIL_ALUBR_NONE, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    v[7]  = '{kSAIL_ALUCTL_SLL, kSAIL_ALUBR_NONE, 1'b0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0};
    v[8]  = '{kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_BLTU, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0};
    v[9]  = '{kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_BLT, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0};
    v[10] = '{kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_BNE, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0, 1'b0, 1'b0};
    v[11] = '{kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_BEQ, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0, 1'b1, 1'b0};
    v[12] = '{kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_BGE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0};
    v[13] = '{kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_BGEU, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0};
    v[14] = '{kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_NONE, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b1};
    v[15] = '{4'd9, kSAIL_ALUBR_NONE, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0, 1'b0, 1'b1};
    v[16] = '{kSAIL_ALUCTL_ADD, kSAIL_ALUBR_NONE, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    bus.in_valid_i = 0;
    bus.out_ready_i = 1;
    drive(kSAIL_ALUCTL_ADD, 3'd0, 0, 0, 0);
    bus.in_valid_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 0, 32'(bus.in_ready_o), 0);
    chk("rst_valid", 0, 32'(bus.out_valid_o), 0);
    chk("rst_result", 0, bus.result_o, 0);
    chk("rst_taken", 0, 32'(bus.branch_taken_o), 0);
    chk("rst_illegal", 0, 32'(bus.illegal_o), 0);
    rst = 0;
    #1 chk("rst_ready_after", 0, 32'(bus.in_ready_o), 1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i > 0) check_vec(i - 1);
      drive(v[i].op, v[i].br, v[i].uns, v[i].a, v[i].b);
      #1 chk("vec_ready", i, 32'(bus.in_ready_o), 1);
    end
    @(negedge clk);
    check_vec(16);
    bus.in_valid_i = 0;
    @(negedge clk);
    chk("idle_valid", 0, 32'(bus.out_valid_o), 0);
    do_shift(0, kSAIL_ALUCTL_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31);
    do_shift(1, kSAIL_ALUCTL_SLL, 32'h0000_0001, 32'd1, 32'h0000_0002, 1);
    do_shift(2, kSAIL_ALUCTL_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 31);
    do_shift(3, kSAIL_ALUCTL_SRA, 32'h4000_0000, 32'd4, 32'h0400_0000, 4);
    do_shift(4, kSAIL_ALUCTL_SLL, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h8000_0000, 31);
    // back-pressure: result held while a competing op waits upstream
    @(negedge clk);
    bus.out_ready_i = 0;
    drive(kSAIL_ALUCTL_ADD, 3'd0, 0, 32'd3, 32'd4);
    @(negedge clk);
    drive(kSAIL_ALUCTL_XOR, 3'd0, 0, 32'd1, 32'd3);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (!bus.out_valid_o || bus.result_o !== 32'd7 || bus.in_ready_o || bus.illegal_o || bus.branch_taken_o) seen++;
      @(negedge clk);
    end
    chk("bp_stable", 0, seen, 0);
    chk("bp_result", 0, bus.result_o, 32'd7);
    bus.out_ready_i = 1;
    #1 chk("bp_ready", 0, 32'(bus.in_ready_o), 1);
    @(negedge clk);
    bus.in_valid_i = 0;
    chk("bp_reload_valid", 0, 32'(bus.out_valid_o), 1);
    chk("bp_reload_result", 0, bus.result_o, 32'd2);
    @(negedge clk);
    chk("bp_idle", 0, 32'(bus.out_valid_o), 0);
    // reset in the middle of a long shift
    drive(kSAIL_ALUCTL_SLL, 3'd0, 0, 32'h0000_0001, 32'd20);
    @(negedge clk);
    bus.in_valid_i = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    #1 chk("mid_rst_ready", 0, 32'(bus.in_ready_o), 0);
    @(negedge clk);
    rst = 0;
    #1 chk("mid_rst_ready_after", 0, 32'(bus.in_ready_o), 1);
    chk("mid_rst_valid", 0, 32'(bus.out_valid_o), 0);
    chk("mid_rst_result", 0, bus.result_o, 0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.out_valid_o) seen++;
    end
    chk("mid_rst_no_result", 0, seen, 0);
    // illegal op held in DONE, then reset
    bus.out_ready_i = 0;
    drive(kSAIL_ALUCTL_ILLEGAL, kSAIL_ALUBR_NONE, 0, 32'hDEAD_BEEF, 32'h1);
    @(negedge clk);
    bus.in_valid_i = 0;
    chk("ill_valid", 0, 32'(bus.out_valid_o), 1);
    chk("ill_flag", 0, 32'(bus.illegal_o), 1);
    chk("ill_result", 0, bus.result_o, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("ill_rst_valid", 0, 32'(bus.out_valid_o), 0);
    chk("ill_rst_flag", 0, 32'(bus.illegal_o), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
